// File: rtl/packetizer_tx_if.sv
// Payload-side handshake and link-side outputs of the packetizer transmit end.
// The slave modport is the packetizer's view; master is the view of the block that drives it.
interface packetizer_tx_if #(
   parameter int unsigned PAYLOAD_WIDTH = 128,
   parameter int unsigned PACKET_WIDTH  = 16
);
   logic [PAYLOAD_WIDTH-1:0] payload_i;
   logic                     payload_valid_i;
   logic                     payload_ready_o;
   logic                     packet_af_i;
   logic [PACKET_WIDTH-1:0]  packet_o;
   logic                     busy_o;
   logic                     pkt_sent_o;

   modport slave (
      input  payload_i,
      input  payload_valid_i,
      input  packet_af_i,
      output payload_ready_o,
      output packet_o,
      output busy_o,
      output pkt_sent_o
   );

   modport master (
      output payload_i,
      output payload_valid_i,
      output packet_af_i,
      input  payload_ready_o,
      input  packet_o,
      input  busy_o,
      input  pkt_sent_o
   );
endinterface

// File: rtl/packetizer_tx.sv
// Transmit end of the serdes packet link: buffers payloads and sends each one as
// a header packet followed by back-to-back data packets, LSB chunk first.
module packetizer_tx #(
   parameter int unsigned PAYLOAD_WIDTH  = 128,
   parameter int unsigned PACKET_WIDTH   = 16,
   parameter int unsigned ID             = 0,
   parameter int unsigned FIFO_DEPTH     = 2,
   parameter int unsigned FIFO_DEPTH_LOG = 1,
   parameter string       INST_NAME      = "Packetizer"
) (
   input  logic           reset,
   input  logic           clk_packet,
   packetizer_tx_if.slave bus
);
   localparam int unsigned N_PKTS     = PAYLOAD_WIDTH / PACKET_WIDTH;
   localparam int unsigned N_PKTS_LOG = (N_PKTS + 1 <= 2) ? 0 : $clog2(N_PKTS);
   localparam int unsigned CNT_W      = N_PKTS_LOG + 1;
   localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned MEM_D      = 1 << PTR_W;
   localparam int unsigned FCNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [PACKET_WIDTH-1:0] HEADER =
      PACKET_WIDTH'((N_PKTS << 2) | ((ID & 1) << 1) | 1);

   if ((PAYLOAD_WIDTH % PACKET_WIDTH) != 0 || N_PKTS == 0) begin : g_bad_payload
      $error("%s: PAYLOAD_WIDTH must be a non-zero multiple of PACKET_WIDTH", INST_NAME);
   end
   if (PACKET_WIDTH < N_PKTS_LOG + 3) begin : g_bad_packet
      $error("%s: PACKET_WIDTH too narrow for the header", INST_NAME);
   end
   if (FIFO_DEPTH < 1 || (1 << FIFO_DEPTH_LOG) < FIFO_DEPTH) begin : g_bad_fifo
      $error("%s: FIFO_DEPTH must be >= 1 and fit in FIFO_DEPTH_LOG bits", INST_NAME);
   end

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA
   } state_e;

   state_e                   state_q, state_d;
   logic [PAYLOAD_WIDTH-1:0] mem_q [MEM_D];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]        count_q, count_d;
   logic [PAYLOAD_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [PACKET_WIDTH-1:0]  packet_q, packet_d;
   logic                     ready_q, ready_d;
   logic                     busy_q, busy_d;
   logic                     sent_q, sent_d;
   logic                     push, pop, emit, start, can_start;

   // cnt_q counts data packets still to be sent; DATA with cnt_q==0 is the last data cycle
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      packet_d  = '0;
      sent_d    = 1'b0;
      pop       = 1'b0;
      emit      = 1'b0;
      start     = 1'b0;
      push      = bus.payload_valid_i & ready_q;
      can_start = (count_q != '0) & ~bus.packet_af_i;

      case (state_q)
         IDLE:    start = can_start;
         HDR:     emit  = 1'b1;
         DATA: begin
            emit  = (cnt_q != '0);
            start = (cnt_q == '0) & can_start;
         end
         default: start = 1'b0;
      endcase

      if (emit) begin
         state_d  = DATA;
         packet_d = shreg_q[PACKET_WIDTH-1:0];
         shreg_d  = shreg_q >> PACKET_WIDTH;
         cnt_d    = cnt_q - CNT_W'(1);
         sent_d   = (cnt_q == CNT_W'(1));
      end else if (start) begin
         state_d  = HDR;
         packet_d = HEADER;
         shreg_d  = mem_q[rd_ptr_q];
         cnt_d    = CNT_W'(N_PKTS);
         pop      = 1'b1;
      end else begin
         state_d  = IDLE;
      end

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + FCNT_W'(push) - FCNT_W'(pop);
      ready_d  = (count_d != FCNT_W'(FIFO_DEPTH));
      busy_d   = (state_d != IDLE) | (count_d != '0);
   end

   always_ff @(posedge clk_packet or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         packet_q <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         sent_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         packet_q <= packet_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         sent_q   <= sent_d;
      end
   end

   // Payload storage carries no reset; occupancy is tracked by count_q
   always_ff @(posedge clk_packet) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.payload_i;
      end
   end

   assign bus.packet_o        = packet_q;
   assign bus.payload_ready_o = ready_q;
   assign bus.busy_o          = busy_q;
   assign bus.pkt_sent_o      = sent_q;

`ifndef SYNTHESIS
   always @(posedge clk_packet) begin
      if (!reset) begin
         assert (!$isunknown(bus.payload_valid_i))
            else $error("%s: payload_valid_i is X out of reset", INST_NAME);
      end
   end
`endif
endmodule

// File: tb/tb_packetizer_tx.sv
// Self-checking bench for packetizer_tx: directed scenarios plus random traffic
// checked every cycle against a link-level reference model.
module tb_packetizer_tx;
   localparam int unsigned PAYW   = 128;
   localparam int unsigned PKTW   = 16;
   localparam int unsigned N_PKTS = 8;
   localparam int unsigned DEPTH  = 2;
   localparam logic [15:0] HDR0   = 16'h0021;
   localparam logic [15:0] HDR1   = 16'h0023;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             vld = 1'b0;
   logic             af  = 1'b0;
   logic [PAYW-1:0]  pay = '0;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [PAYW-1:0]  exp_q[$];
   logic [PAYW-1:0]  cur = '0;
   int               rem = 0;
   int               idx = 0;
   logic [PKTW-1:0]  exp_pkt = '0;
   logic             exp_sent = 1'b0;
   logic             is_hdr = 1'b0;
   logic             in_txn = 1'b0;
   logic [PKTW-1:0]  log_q[$];

   always #5 clk = ~clk;

   packetizer_tx_if #(.PAYLOAD_WIDTH(PAYW), .PACKET_WIDTH(PKTW)) if0 ();
   packetizer_tx_if #(.PAYLOAD_WIDTH(PAYW), .PACKET_WIDTH(PKTW)) if1 ();

   assign if0.payload_i       = pay;
   assign if0.payload_valid_i = vld;
   assign if0.packet_af_i     = af;
   assign if1.payload_i       = pay;
   assign if1.payload_valid_i = vld;
   assign if1.packet_af_i     = af;

   packetizer_tx #(.PAYLOAD_WIDTH(PAYW), .PACKET_WIDTH(PKTW), .ID(0), .FIFO_DEPTH(DEPTH),
                   .FIFO_DEPTH_LOG(1), .INST_NAME("tx0"))
      dut0 (.reset(rst), .clk_packet(clk), .bus(if0));

   packetizer_tx #(.PAYLOAD_WIDTH(PAYW), .PACKET_WIDTH(PKTW), .ID(1), .FIFO_DEPTH(DEPTH),
                   .FIFO_DEPTH_LOG(1), .INST_NAME("tx1"))
      dut1 (.reset(rst), .clk_packet(clk), .bus(if1));

   task automatic chk(input string tag, input logic [PAYW-1:0] obs, input logic [PAYW-1:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   function automatic logic [PAYW-1:0] rand_payload();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: the model decides from pre-edge inputs what the link must show after the edge.
   task automatic tick();
      bit accept;
      bit start;
      accept = !rst && vld && (exp_q.size() < DEPTH);
      start  = !rst && (rem == 0) && (exp_q.size() > 0) && !af;
      @(posedge clk);
      @(negedge clk);
      exp_sent = 1'b0;
      is_hdr   = 1'b0;
      if (rst) begin
         exp_q.delete();
         rem     = 0;
         exp_pkt = '0;
         in_txn  = 1'b0;
      end else begin
         in_txn = 1'b1;
         if (start) begin
            cur     = exp_q.pop_front();
            rem     = N_PKTS;
            idx     = 0;
            exp_pkt = HDR0;
            is_hdr  = 1'b1;
         end else if (rem > 0) begin
            exp_pkt  = cur[idx*PKTW +: PKTW];
            idx++;
            rem--;
            exp_sent = (rem == 0);
         end else begin
            exp_pkt = '0;
            in_txn  = 1'b0;
         end
         if (accept) exp_q.push_back(pay);
      end
      log_q.push_back(if0.packet_o);
      chk("packet", PAYW'(if0.packet_o), PAYW'(exp_pkt));
      chk("packet_id1", PAYW'(if1.packet_o), PAYW'(is_hdr ? HDR1 : exp_pkt));
      chk("pkt_sent", PAYW'(if0.pkt_sent_o), PAYW'(exp_sent));
      chk("pkt_sent_id1", PAYW'(if1.pkt_sent_o), PAYW'(exp_sent));
      chk("busy", PAYW'(if0.busy_o), PAYW'(in_txn || (exp_q.size() > 0)));
      chk("ready", PAYW'(if0.payload_ready_o), PAYW'(exp_q.size() < DEPTH));
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      vld  = 1'b0;
      af   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rem == 0 && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      chk("drain_done", PAYW'(done), PAYW'(1'b1));
   endtask

   initial begin
      logic [PKTW-1:0] e;
      bit              hit;

      // reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 1/2: single payload, chunk k = k, seen on both ID instances
      for (int k = 0; k < int'(N_PKTS); k++) pay[k*PKTW +: PKTW] = PKTW'(k);
      vld = 1'b1;
      tick();
      vld = 1'b0;
      log_q.delete();
      repeat (10) tick();
      for (int k = 0; k < 10; k++) begin
         e = (k == 0) ? 16'h0021 : (k <= 8) ? PKTW'(k - 1) : 16'h0000;
         chk("t1_seq", PAYW'(log_q[k]), PAYW'(e));
      end
      drain();

      // 3: almost-full holds off the header
      af  = 1'b1;
      vld = 1'b1;
      pay = rand_payload();
      tick();
      vld = 1'b0;
      repeat (4) tick();
      chk("t3_held_pkt", PAYW'(if0.packet_o), '0);
      chk("t3_held_busy", PAYW'(if0.busy_o), PAYW'(1'b1));
      af = 1'b0;
      tick();
      chk("t3_hdr", PAYW'(if0.packet_o), PAYW'(HDR0));
      drain();

      // 4: three payloads, FIFO fills after two, then 27 gapless packets
      af  = 1'b1;
      vld = 1'b1;
      pay = rand_payload();
      tick();
      pay = rand_payload();
      tick();
      chk("t4_ready_low", PAYW'(if0.payload_ready_o), '0);
      pay = rand_payload();
      repeat (2) tick();
      af = 1'b0;
      log_q.delete();
      tick();
      tick();
      vld = 1'b0;
      repeat (26) tick();
      chk("t4_hdr0", PAYW'(log_q[0]), PAYW'(HDR0));
      chk("t4_hdr9", PAYW'(log_q[9]), PAYW'(HDR0));
      chk("t4_hdr18", PAYW'(log_q[18]), PAYW'(HDR0));
      chk("t4_idle27", PAYW'(log_q[27]), '0);
      drain();

      // 5: af raised mid-transaction does not stall data; next header waits for af low
      vld = 1'b1;
      pay = rand_payload();
      tick();
      pay = rand_payload();
      tick();
      vld = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rem > 0 && idx == 4) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      chk("t5_reach_pkt3", PAYW'(hit), PAYW'(1'b1));
      af = 1'b1;
      for (int i = 0; i < 20 && rem > 0; i++) tick();
      repeat (4) tick();
      chk("t5_held_pkt", PAYW'(if0.packet_o), '0);
      chk("t5_held_busy", PAYW'(if0.busy_o), PAYW'(1'b1));
      af = 1'b0;
      tick();
      chk("t5_hdr", PAYW'(if0.packet_o), PAYW'(HDR0));
      drain();

      // 6: reset during data packet 4, then a full transaction afterwards
      vld = 1'b1;
      pay = rand_payload();
      tick();
      pay = rand_payload();
      tick();
      vld = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rem > 0 && idx == 5) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      chk("t6_reach_pkt4", PAYW'(hit), PAYW'(1'b1));
      rst = 1'b1;
      #1;
      chk("t6_rst_pkt", PAYW'(if0.packet_o), '0);
      chk("t6_rst_ready", PAYW'(if0.payload_ready_o), PAYW'(1'b1));
      chk("t6_rst_busy", PAYW'(if0.busy_o), '0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      vld = 1'b1;
      pay = rand_payload();
      tick();
      vld = 1'b0;
      drain();

      // random traffic with occasional almost-full
      for (int i = 0; i < 400; i++) begin
         vld = 1'($urandom_range(0, 1));
         af  = ($urandom_range(0, 7) == 0);
         if (vld) pay = rand_payload();
         tick();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
